// File: rtl/ctrl_hazard_unit.sv
// Control-flow hazard unit: stalls fetch on a jump/branch in ID and waits for EX to resolve it.
// It then issues a one-cycle registered PC redirect and keeps a saturating count of bubble cycles.
module ctrl_hazard_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_is_cf,
  input  logic             ex_resolve,
  input  logic             ex_taken,
  input  logic [XLEN-1:0]  ex_target,
  input  logic [XLEN-1:0]  ex_fallthru,
  input  logic             flush,
  output logic             need_bubble_id,
  output logic             need_bubble_ex,
  output logic             pc_stall,
  output logic             pc_redirect_en,
  output logic [XLEN-1:0]  pc_redirect_target,
  output logic             timeout_err,
  output logic [CNT_W-1:0] perf_bubbles
);

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RES,
    REDIRECT
  } state_t;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             redirect_en_q, redirect_en_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] perf_q, perf_d;
  logic             hazard_id;

  always_comb begin
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    redirect_en_d  = 1'b0;
    target_d       = target_q;
    timeout_err_d  = timeout_err_q;
    need_bubble_id = 1'b0;
    need_bubble_ex = 1'b0;
    pc_stall       = 1'b0;
    perf_d         = perf_q;
    hazard_id      = id_valid & id_is_cf;

    case (state_q)
      IDLE: begin
        need_bubble_id = hazard_id;
        pc_stall       = hazard_id;
        if (hazard_id) begin
          state_d   = WAIT_RES;
          tmo_cnt_d = '0;
        end
      end
      WAIT_RES: begin
        need_bubble_ex = 1'b1;
        pc_stall       = 1'b1;
        if (ex_resolve) begin
          state_d       = REDIRECT;
          redirect_en_d = 1'b1;
          target_d      = ex_taken ? ex_target : ex_fallthru;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      REDIRECT: begin
        // PC is released here so it loads the redirect target this cycle
        need_bubble_ex = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A flush abandons any tracked instruction but leaves this cycle's bubbles alone
    if (flush) begin
      state_d       = IDLE;
      tmo_cnt_d     = '0;
      redirect_en_d = 1'b0;
      target_d      = target_q;
      timeout_err_d = timeout_err_q;
    end

    if (rst) begin
      need_bubble_id = 1'b0;
      need_bubble_ex = 1'b0;
      pc_stall       = 1'b0;
    end

    if ((need_bubble_id | need_bubble_ex) && (perf_q != '1)) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      redirect_en_q <= 1'b0;
      target_q      <= '0;
      timeout_err_q <= 1'b0;
      perf_q        <= '0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      redirect_en_q <= redirect_en_d;
      target_q      <= target_d;
      timeout_err_q <= timeout_err_d;
      perf_q        <= perf_d;
    end
  end

  assign pc_redirect_en     = redirect_en_q;
  assign pc_redirect_target = target_q;
  assign timeout_err        = timeout_err_q;
  assign perf_bubbles       = perf_q;

endmodule
